layer_compositor: RTL and testbench

//  Parametrised successor of the game graphics top: N-layer pixel compositor with per-layer palette, aligned sync pipeline,

---
 rtl/layer_compositor_pkg.sv | 31 +++
 rtl/hvsync_generator.sv | 53 +++++
 rtl/layer_priority_mux.sv | 22 ++
 rtl/layer_compositor.sv | 192 +++++++++++++++++++
 tb/tb_layer_compositor.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared definitions for the layer compositor: colour defaults, RGB field
// helper, VGA timing constants and the per-pixel scan record.
package layer_compositor_pkg;

    localparam int DEF_COLOR_BITS = 2;

    // 640x480 @ 60 Hz timing, in pixel clocks / lines
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    // Scan state carried along the display pipeline
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic [9:0] hpos;
        logic [9:0] vpos;
    } scan_t;

    // LSB position of channel ch (0=R, 1=G, 2=B) inside a packed {R,G,B} word
    function automatic int rgb_lsb(input int cb, input int ch);
        return (2 - ch) * cb;
    endfunction

endpackage

// File: rtl/hvsync_generator.sv
// Horizontal/vertical scan counter with combinational sync and display-enable
// decode. Syncs are active-high during the sync pulse.
module hvsync_generator
    import layer_compositor_pkg::*;
#(
    parameter int H_DISP = H_DISPLAY,
    parameter int H_FP   = H_FRONT,
    parameter int H_SW   = H_SYNC,
    parameter int H_BP   = H_BACK,
    parameter int V_DISP = V_DISPLAY,
    parameter int V_FP   = V_FRONT,
    parameter int V_SW   = V_SYNC,
    parameter int V_BP   = V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_display_on,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SW + V_BP;

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       w_hmax;
    logic       w_vmax;

    assign w_hmax = (r_hpos == 10'(H_TOTAL - 1));
    assign w_vmax = (r_vpos == 10'(V_TOTAL - 1));

    // Raster scan: hpos wraps every line, vpos advances at each line end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (w_hmax) begin
            r_hpos <= '0;
            r_vpos <= w_vmax ? 10'd0 : r_vpos + 10'd1;
        end else begin
            r_hpos <= r_hpos + 10'd1;
        end
    end

    assign o_hsync      = (r_hpos >= 10'(H_DISP + H_FP)) && (r_hpos < 10'(H_DISP + H_FP + H_SW));
    assign o_vsync      = (r_vpos >= 10'(V_DISP + V_FP)) && (r_vpos < 10'(V_DISP + V_FP + V_SW));
    assign o_display_on = (r_hpos < 10'(H_DISP)) && (r_vpos < 10'(V_DISP));
    assign o_hpos       = r_hpos;
    assign o_vpos       = r_vpos;

endmodule

// File: rtl/layer_priority_mux.sv
// Picks the highest-index asserted layer hit; o_valid low when none is set.
module layer_priority_mux #(
    parameter  int NUM_LAYERS = 4,
    localparam int IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] i_hits,
    output logic [IW-1:0]         o_index,
    output logic                  o_valid
);
    // Later (higher) indices overwrite earlier ones, so the top set bit wins
    always_comb begin
        o_index = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (i_hits[k]) begin
                o_index = IW'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: priority palette lookup, aligned sync pipeline,
// frame tick divider, flash inversion and sticky masked collision capture.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_BITS   = DEF_COLOR_BITS,
    parameter int CONV         = 0,
    parameter int PIPE         = 2,
    parameter int TICK_DIV     = 3,
    parameter int FLASH_FRAMES = 8,
    parameter int H_DISP       = H_DISPLAY,
    parameter int H_FP         = H_FRONT,
    parameter int H_SW         = H_SYNC,
    parameter int H_BP         = H_BACK,
    parameter int V_DISP       = V_DISPLAY,
    parameter int V_FP         = V_FRONT,
    parameter int V_SW         = V_SYNC,
    parameter int V_BP         = V_BACK
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             o_hsync,
    output logic                             o_vsync,
    output logic [COLOR_BITS-1:0]            o_red,
    output logic [COLOR_BITS-1:0]            o_green,
    output logic [COLOR_BITS-1:0]            o_blue,
    output logic [9-CONV:0]                  o_hpos,
    output logic [9-CONV:0]                  o_vpos,
    input  logic [NUM_LAYERS-1:0]            i_layer,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] i_palette,
    input  logic [3*COLOR_BITS-1:0]          i_bg_color,
    input  logic                             i_invert,
    input  logic                             i_flash_en,
    input  logic [NUM_LAYERS-1:0]            i_coll_mask_a,
    input  logic [NUM_LAYERS-1:0]            i_coll_mask_b,
    input  logic                             i_coll_clear,
    output logic                             o_tick_frame,
    output logic                             o_tick_div,
    output logic                             o_tick_div_r,
    output logic                             o_collision,
    output logic [9:0]                       o_coll_x,
    output logic [9:0]                       o_coll_y
);
    localparam int CW  = 3 * COLOR_BITS;
    localparam int IW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int FCW = $clog2(TICK_DIV);
    localparam int FLW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic       w_hs;
    logic       w_vs;
    logic       w_de;
    logic [9:0] w_hpos;
    logic [9:0] w_vpos;

    hvsync_generator #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_hvsync (
        .clk          (clk),
        .rst          (rst),
        .o_hsync      (w_hs),
        .o_vsync      (w_vs),
        .o_display_on (w_de),
        .o_hpos       (w_hpos),
        .o_vpos       (w_vpos)
    );

    assign o_hpos = w_hpos[9:CONV];
    assign o_vpos = w_vpos[9:CONV];

    // ---------------- scan pipeline ----------------
    scan_t w_live;
    scan_t w_samp;              // stage PIPE-1: the pixel i_layer refers to
    scan_t r_pipe [1:PIPE];

    assign w_live = '{hsync: w_hs, vsync: w_vs, display_on: w_de, hpos: w_hpos, vpos: w_vpos};

    // Shift scan state towards the pins; reset flushes to blank
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= PIPE; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[1] <= w_live;
            for (int k = 2; k <= PIPE; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    generate
        if (PIPE == 1) begin : g_samp_direct
            assign w_samp = w_live;
        end else begin : g_samp_delayed
            assign w_samp = r_pipe[PIPE-1];
        end
    endgenerate

    assign o_hsync = r_pipe[PIPE].hsync;
    assign o_vsync = r_pipe[PIPE].vsync;

    // ---------------- colour ----------------
    logic [IW-1:0] w_win_idx;
    logic          w_win_valid;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_color_next;
    logic [CW-1:0] w_shown;
    logic [CW-1:0] r_color;
    logic [FLW-1:0] r_flash_cnt;
    logic           r_flash_phase;

    layer_priority_mux #(.NUM_LAYERS(NUM_LAYERS)) u_prio (
        .i_hits  (i_layer),
        .o_index (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_base       = w_win_valid ? i_palette[int'(w_win_idx)*CW +: CW] : i_bg_color;
    assign w_color_next = w_base ^ {CW{i_invert ^ r_flash_phase}};

    // Colour register lines up with the last pipeline stage
    always_ff @(posedge clk) begin
        if (rst) r_color <= '0;
        else     r_color <= w_color_next;
    end

    // Blanking forces black regardless of inversion
    assign w_shown = r_pipe[PIPE].display_on ? r_color : '0;
    assign o_red   = w_shown[rgb_lsb(COLOR_BITS, 0) +: COLOR_BITS];
    assign o_green = w_shown[rgb_lsb(COLOR_BITS, 1) +: COLOR_BITS];
    assign o_blue  = w_shown[rgb_lsb(COLOR_BITS, 2) +: COLOR_BITS];

    // ---------------- ticks ----------------
    logic [FCW-1:0] r_frame_cnt;
    logic           r_tick_div_r;

    assign o_tick_frame = (w_hpos == 10'd0) && (w_vpos == 10'd0);
    assign o_tick_div   = o_tick_frame && (r_frame_cnt == FCW'(TICK_DIV - 1));
    assign o_tick_div_r = r_tick_div_r;

    // Count frames modulo TICK_DIV; delayed copy of the divided tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt  <= '0;
            r_tick_div_r <= 1'b0;
        end else begin
            r_tick_div_r <= o_tick_div;
            if (o_tick_frame) r_frame_cnt <= o_tick_div ? '0 : r_frame_cnt + 1'b1;
        end
    end

    // Flash phase toggles every FLASH_FRAMES frames while enabled
    always_ff @(posedge clk) begin
        if (rst || !i_flash_en) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= 1'b0;
        end else if (o_tick_frame) begin
            if (r_flash_cnt == FLW'(FLASH_FRAMES - 1)) begin
                r_flash_cnt   <= '0;
                r_flash_phase <= ~r_flash_phase;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end
    end

    // ---------------- collision ----------------
    logic       w_hit;
    logic       r_coll;
    logic [9:0] r_coll_x;
    logic [9:0] r_coll_y;

    assign w_hit = (|(i_layer & i_coll_mask_a)) && (|(i_layer & i_coll_mask_b)) && w_samp.display_on;

    // Sticky flag with first-hit coordinates; clear beats a same-cycle hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coll   <= 1'b0;
            r_coll_x <= '0;
            r_coll_y <= '0;
        end else if (i_coll_clear) begin
            r_coll <= 1'b0;
        end else if (w_hit && !r_coll) begin
            r_coll   <= 1'b1;
            r_coll_x <= w_samp.hpos;
            r_coll_y <= w_samp.vpos;
        end
    end

    assign o_collision = r_coll;
    assign o_coll_x    = r_coll_x;
    assign o_coll_y    = r_coll_y;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor on a shrunken raster. Expected values
// come from a cycle-index model: pixel position is derived from the number of
// clock edges since reset, and colour/flash/collision follow the stated rules.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CB = 2;
    localparam int CW = 3 * CB;
    localparam int PIPE = 2;
    localparam int TD = 3;
    localparam int FF = 8;
    localparam int HD = 24, HF = 2, HS = 4, HB = 2;
    localparam int VD = 16, VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic              clk = 1'b0;
    logic              rst;
    logic              o_hsync, o_vsync;
    logic [CB-1:0]     o_red, o_green, o_blue;
    logic [9:0]        o_hpos, o_vpos;
    logic [NL-1:0]     i_layer;
    logic [NL*CW-1:0]  i_palette;
    logic [CW-1:0]     i_bg_color;
    logic              i_invert, i_flash_en, i_coll_clear;
    logic [NL-1:0]     i_coll_mask_a, i_coll_mask_b;
    logic              o_tick_frame, o_tick_div, o_tick_div_r, o_collision;
    logic [9:0]        o_coll_x, o_coll_y;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS(NL), .COLOR_BITS(CB), .CONV(0), .PIPE(PIPE),
        .TICK_DIV(TD), .FLASH_FRAMES(FF),
        .H_DISP(HD), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SW(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst),
        .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_hpos(o_hpos), .o_vpos(o_vpos),
        .i_layer(i_layer), .i_palette(i_palette), .i_bg_color(i_bg_color),
        .i_invert(i_invert), .i_flash_en(i_flash_en),
        .i_coll_mask_a(i_coll_mask_a), .i_coll_mask_b(i_coll_mask_b),
        .i_coll_clear(i_coll_clear),
        .o_tick_frame(o_tick_frame), .o_tick_div(o_tick_div), .o_tick_div_r(o_tick_div_r),
        .o_collision(o_collision), .o_coll_x(o_coll_x), .o_coll_y(o_coll_y)
    );

    int total = 0;
    int bad = 0;
    int div_pulses = 0;

    // model state
    int            mc = 0;          // clock edges since reset release
    logic [CW-1:0] m_color_reg = '0;
    int            m_flash_ticks = 0;
    bit            m_coll = 1'b0;
    int            m_cx = 0, m_cy = 0;

    function automatic int hp(input int n); return n % HT; endfunction
    function automatic int vp(input int n); return (n / HT) % VT; endfunction
    function automatic bit de_at(input int n); return (n >= 0) && hp(n) < HD && vp(n) < VD; endfunction
    function automatic bit hs_at(input int n); return (n >= 0) && hp(n) >= HD + HF && hp(n) < HD + HF + HS; endfunction
    function automatic bit vs_at(input int n); return (n >= 0) && vp(n) >= VD + VF && vp(n) < VD + VF + VS; endfunction
    function automatic bit tf_at(input int n); return (n >= 0) && (n % FT) == 0; endfunction
    function automatic bit td_at(input int n); return tf_at(n) && ((n / FT) % TD) == TD - 1; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, mc);
        end
    endtask

    // Apply one clock edge to the model using the inputs held across it
    task automatic model_edge();
        int            ns;
        int            win;
        bit            phase;
        bit            hit;
        logic [CW-1:0] base;
        if (rst) begin
            mc = 0; m_color_reg = '0; m_flash_ticks = 0;
            m_coll = 1'b0; m_cx = 0; m_cy = 0;
        end else begin
            ns = mc - (PIPE - 1);
            phase = ((m_flash_ticks / FF) % 2) == 1;
            win = -1;
            for (int k = NL - 1; k >= 0; k--) begin
                if (win < 0 && i_layer[k]) win = k;
            end
            base = (win >= 0) ? i_palette[win*CW +: CW] : i_bg_color;
            m_color_reg = base ^ {CW{i_invert ^ phase}};
            if (!i_flash_en) m_flash_ticks = 0;
            else if (tf_at(mc)) m_flash_ticks++;
            hit = ((i_layer & i_coll_mask_a) != 0) && ((i_layer & i_coll_mask_b) != 0) && de_at(ns);
            if (i_coll_clear) m_coll = 1'b0;
            else if (hit && !m_coll) begin
                m_coll = 1'b1; m_cx = hp(ns); m_cy = vp(ns);
            end
            mc++;
        end
    endtask

    task automatic step();
        logic [CW-1:0] exp_rgb;
        @(posedge clk);
        model_edge();
        #1;
        exp_rgb = de_at(mc - PIPE) ? m_color_reg : '0;
        chk("hsync", 32'(o_hsync), 32'(hs_at(mc - PIPE)));
        chk("vsync", 32'(o_vsync), 32'(vs_at(mc - PIPE)));
        chk("rgb", 32'({o_red, o_green, o_blue}), 32'(exp_rgb));
        chk("hpos", 32'(o_hpos), 32'(hp(mc)));
        chk("vpos", 32'(o_vpos), 32'(vp(mc)));
        chk("tick_frame", 32'(o_tick_frame), 32'(tf_at(mc)));
        chk("tick_div", 32'(o_tick_div), 32'(td_at(mc)));
        chk("tick_div_r", 32'(o_tick_div_r), 32'((mc >= 1) && td_at(mc - 1)));
        chk("collision", 32'(o_collision), 32'(m_coll));
        chk("coll_x", 32'(o_coll_x), 32'(m_cx));
        chk("coll_y", 32'(o_coll_y), 32'(m_cy));
        if (o_tick_div === 1'b1) div_pulses++;
    endtask

    task automatic rand_pixel();
        i_layer    = ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom);
        i_palette  = (NL*CW)'($urandom);
        i_bg_color = CW'($urandom);
    endtask

    // Current stage PIPE-1 position matches (x,y)
    function automatic bit samp_at(input int x, input int y);
        int ns;
        ns = mc - (PIPE - 1);
        return (ns >= 0) && hp(ns) == x && vp(ns) == y;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit was_clear;
        rst = 1'b1;
        i_layer = '0; i_palette = '0; i_bg_color = '0;
        i_invert = 1'b0; i_flash_en = 1'b0; i_coll_clear = 1'b0;
        i_coll_mask_a = '0; i_coll_mask_b = '0;

        // reset: everything registered reads zero
        repeat (5) step();
        rst = 1'b0;
        div_pulses = 0;

        // nine frames of random pixels; divided tick on frames 2, 5, 8
        for (int i = 0; i < 9 * FT; i++) begin
            rand_pixel();
            step();
        end
        chk("div_pulses_9_frames", 32'(div_pulses), 32'd3);

        // priority: L3 beats L1, then the same frame inverted
        i_palette = '0;
        i_palette[3*CW +: CW] = 6'b110000;
        i_palette[1*CW +: CW] = 6'b001100;
        i_layer = 4'b1010;
        for (int f = 0; f < 2; f++) begin
            i_invert = (f == 1);
            for (int i = 0; i < FT; i++) begin
                i_bg_color = CW'($urandom);
                step();
                if (mc - PIPE >= 0 && hp(mc - PIPE) == 5 && vp(mc - PIPE) == 5)
                    chk(f == 0 ? "prio_1010" : "prio_1010_inv", 32'({o_red, o_green, o_blue}),
                        f == 0 ? 32'h30 : 32'h0f);
            end
        end

        // flash mode across several half-periods, random invert
        i_flash_en = 1'b1;
        for (int i = 0; i < 20 * FT; i++) begin
            rand_pixel();
            if ((i % 97) == 0) i_invert = 1'($urandom);
            step();
        end
        i_flash_en = 1'b0;
        i_invert = 1'b0;

        // directed collision: first hit at (20,10), later one at (22,10)
        i_coll_mask_a = 4'b0001;
        i_coll_mask_b = 4'b0100;
        i_layer = '0;
        i_coll_clear = 1'b1;
        step();
        i_coll_clear = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            i_layer = (samp_at(20, 10) || samp_at(22, 10)) ? 4'b0101 : 4'b0000;
            step();
        end
        chk("coll_flag_directed", 32'(o_collision), 32'd1);
        chk("coll_x_directed", 32'(o_coll_x), 32'd20);
        chk("coll_y_directed", 32'(o_coll_y), 32'd10);

        // clear with a simultaneous hit at (5,3), then a hit at (6,3)
        for (int i = 0; i < 2 * FT; i++) begin
            i_coll_clear = samp_at(5, 3);
            i_layer = (samp_at(5, 3) || samp_at(6, 3)) ? 4'b0101 : 4'b0000;
            was_clear = i_coll_clear;
            step();
            if (was_clear) chk("coll_clear_wins", 32'(o_collision), 32'd0);
        end
        i_coll_clear = 1'b0;
        chk("coll_x_after_clear", 32'(o_coll_x), 32'd6);
        chk("coll_y_after_clear", 32'(o_coll_y), 32'd3);

        // random masks, layers and occasional clears
        for (int i = 0; i < 2 * FT; i++) begin
            rand_pixel();
            if ((i % 211) == 0) begin
                i_coll_mask_a = NL'($urandom);
                i_coll_mask_b = NL'($urandom);
            end
            i_coll_clear = ($urandom_range(0, 63) == 0);
            step();
        end
        i_coll_clear = 1'b0;

        // reset in mid-frame, then carry on
        for (int i = 0; i < FT / 2 + 7; i++) begin
            rand_pixel();
            step();
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        i_flash_en = 1'b1;
        for (int i = 0; i < FT + FT / 2; i++) begin
            rand_pixel();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
